// File: rtl/perf_counter_collector_if.sv
// Valid/ready stream carrying one snapshotted counter per beat: index, value and last-entry flag.
interface perf_counter_collector_if #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned ID_WIDTH  = 4
);
  logic                 out_valid;
  logic                 out_ready;
  logic [ID_WIDTH-1:0]  out_id;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_id,
    output out_count,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    input  out_count,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/perf_counter_collector.sv
// Saturating performance-event counters with an atomic snapshot that is streamed out one per beat.
// Define PERF_DUMP_SKIP_ZERO_EN to drop zero-valued entries, except the final terminator entry.
module perf_counter_collector #(
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_EVENTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_EVENTS-1:0]   event_i,
  input  logic                    dump_req,
  input  logic                    clear_on_dump,
  input  logic                    clear_req,
  output logic                    busy,
  perf_counter_collector_if.master stream
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [ID_WIDTH-1:0]  LastIdx = ID_WIDTH'(NUM_EVENTS - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] cnt_d    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] shadow_d [NUM_EVENTS];

  logic                 dump_accept;
  logic                 clear_live;
  logic                 idx_last;
  logic                 entry_emit;
  logic [CNT_WIDTH-1:0] cur_count;

  assign dump_accept = (state_q == StIdle) && dump_req;
  assign clear_live  = clear_req || (dump_accept && clear_on_dump);
  assign idx_last    = (idx_q == LastIdx);
  assign cur_count   = shadow_q[idx_q];

`ifdef PERF_DUMP_SKIP_ZERO_EN
  // The last index always goes out so the consumer sees a terminator.
  assign entry_emit = idx_last || (cur_count != '0);
`else
  assign entry_emit = 1'b1;
`endif

  // Live counters: a clear still lets this cycle's event land as a count of 1.
  always_comb begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_live) begin
        cnt_d[i] = CNT_WIDTH'(event_i[i]);
      end else if (event_i[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Snapshot takes the pre-increment value so the dump is atomic at the request edge.
  always_comb begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      shadow_d[i] = dump_accept ? cnt_q[i] : shadow_q[i];
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    busy             = 1'b0;
    stream.out_valid = 1'b0;
    stream.out_id    = '0;
    stream.out_count = '0;
    stream.out_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_req) begin
          state_d = StSend;
          idx_d   = '0;
        end
      end
      StSend: begin
        busy             = 1'b1;
        stream.out_valid = entry_emit;
        stream.out_id    = idx_q;
        stream.out_count = cur_count;
        stream.out_last  = idx_last;
        // Skipped entries advance without waiting for the consumer.
        if (!entry_emit || stream.out_ready) begin
          if (idx_last) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + ID_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_collector.sv
// Scoreboard bench for perf_counter_collector: a count-level model queues expected dump entries.
module tb_perf_counter_collector;
  localparam int unsigned NE = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 4;
  localparam longint unsigned CMAX = (64'd1 << CW) - 1;

  typedef struct {
    logic [IW-1:0] id;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [NE-1:0] event_i;
  logic          dump_req;
  logic          clear_on_dump;
  logic          clear_req;
  logic          busy;

  perf_counter_collector_if #(.CNT_WIDTH(CW), .ID_WIDTH(IW)) out_if ();

  perf_counter_collector #(
    .NUM_EVENTS(NE),
    .CNT_WIDTH (CW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .event_i      (event_i),
    .dump_req     (dump_req),
    .clear_on_dump(clear_on_dump),
    .clear_req    (clear_req),
    .busy         (busy),
    .stream       (out_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint unsigned mcnt [NE];
  exp_t            q [$];
  bit              mbusy;
  bit              was_busy;
  bit              acc;
  bit              stalled;
  logic [IW-1:0]   st_id;
  logic [CW-1:0]   st_cnt;
  exp_t            e;

  // Model and monitor run together on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) mcnt[i] = 0;
      q.delete();
      mbusy   = 1'b0;
      stalled = 1'b0;
    end else begin
      checks++;
      if (busy !== mbusy) begin
        errors++;
        $display("FAIL busy got %0b exp %0b at %0t", busy, mbusy, $time);
      end
`ifndef PERF_DUMP_SKIP_ZERO_EN
      checks++;
      if (out_if.out_valid !== mbusy) begin
        errors++;
        $display("FAIL out_valid got %0b exp %0b at %0t", out_if.out_valid, mbusy, $time);
      end
`endif
      if (stalled) begin
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_id !== st_id || out_if.out_count !== st_cnt) begin
          errors++;
          $display("FAIL stall_hold got v%0b id%0h cnt%0h exp v1 id%0h cnt%0h at %0t",
                   out_if.out_valid, out_if.out_id, out_if.out_count, st_id, st_cnt, $time);
        end
      end
      stalled = (out_if.out_valid === 1'b1) && (out_if.out_ready === 1'b0);
      st_id   = out_if.out_id;
      st_cnt  = out_if.out_count;

      was_busy = mbusy;
      if (out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry got id%0h cnt%0h exp none at %0t",
                   out_if.out_id, out_if.out_count, $time);
        end else begin
          e = q.pop_front();
          if (out_if.out_id !== e.id || out_if.out_count !== e.cnt || out_if.out_last !== e.last) begin
            errors++;
            $display("FAIL entry got id%0h cnt%0h last%0b exp id%0h cnt%0h last%0b at %0t",
                     out_if.out_id, out_if.out_count, out_if.out_last, e.id, e.cnt, e.last, $time);
          end
          if (e.last) mbusy = 1'b0;
        end
      end

      acc = !was_busy && (dump_req === 1'b1);
      if (acc) begin
        for (int i = 0; i < NE; i++) begin
          e.id   = IW'(i);
          e.cnt  = CW'(mcnt[i]);
          e.last = (i == NE - 1);
`ifdef PERF_DUMP_SKIP_ZERO_EN
          if (mcnt[i] != 0 || i == NE - 1) q.push_back(e);
`else
          q.push_back(e);
`endif
        end
        mbusy = 1'b1;
      end

      for (int i = 0; i < NE; i++) begin
        if (clear_req || (acc && clear_on_dump)) mcnt[i] = event_i[i] ? 1 : 0;
        else if (event_i[i] && mcnt[i] < CMAX) mcnt[i] = mcnt[i] + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ev, input int n);
    for (int k = 0; k < n; k++) begin
      event_i     = '0;
      event_i[ev] = 1'b1;
      step();
    end
    event_i = '0;
  endtask

  task automatic dump(input bit cod, input logic [NE-1:0] ev);
    dump_req      = 1'b1;
    clear_on_dump = cod;
    event_i       = ev;
    step();
    dump_req      = 1'b0;
    clear_on_dump = 1'b0;
    event_i       = '0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    step();
    while (busy !== 1'b0 && n < max) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle got busy %0b exp 0 after %0d cycles", busy, max);
    end
  endtask

  logic [NE-1:0] ev1;

  initial begin
    rst              = 1'b1;
    event_i          = '0;
    dump_req         = 1'b0;
    clear_on_dump    = 1'b0;
    clear_req        = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic counts and full in-order dump.
    pulse(3, 5);
    pulse(0, 2);
    dump(1'b0, '0);
    wait_idle(40);

    // Saturation at all-ones.
    pulse(5, int'(CMAX) + 3);
    dump(1'b0, '0);
    wait_idle(40);

    // Clear-on-dump with a same-cycle event.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    pulse(1, 7);
    ev1    = '0;
    ev1[1] = 1'b1;
    dump(1'b1, ev1);
    wait_idle(40);
    pulse(1, 2);
    dump(1'b0, '0);
    wait_idle(40);

    // Backpressure plus an ignored mid-stream dump request.
    pulse(7, 4);
    dump(1'b0, '0);
    step();
    out_if.out_ready = 1'b0;
    dump_req         = 1'b1;
    step();
    dump_req = 1'b0;
    step();
    out_if.out_ready = 1'b1;
    wait_idle(40);

    // Reset in the middle of a stream.
    pulse(2, 3);
    dump(1'b0, '0);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dump(1'b0, '0);
    wait_idle(40);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      event_i          = NE'($urandom & $urandom & $urandom);
      out_if.out_ready = ($urandom_range(0, 3) != 0);
      dump_req         = ($urandom_range(0, 19) == 0);
      clear_on_dump    = ($urandom_range(0, 2) == 0);
      clear_req        = ($urandom_range(0, 59) == 0);
      rst              = ($urandom_range(0, 499) == 0);
      step();
    end
    event_i          = '0;
    dump_req         = 1'b0;
    clear_on_dump    = 1'b0;
    clear_req        = 1'b0;
    rst              = 1'b0;
    out_if.out_ready = 1'b1;
    wait_idle(60);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_collector.md
Name: perf_counter_collector

Overview:
- Reader side of the per-module performance-event pulses that the design raises behind its perf hooks.
- Owns NUM_EVENTS saturating event counters.
- On a dump request, snapshots all counters atomically and streams them out one per cycle over a valid/ready interface to the difftest/trace host bridge.
- Sits at SoC top next to the debug bridge; events are fanned in from core, caches and predictors.

Parameters:
- NUM_EVENTS, 16, number of event inputs and counters (>=2).
- CNT_WIDTH, 32, width of each counter and of out_count.
- ID_WIDTH, $clog2(NUM_EVENTS), width of out_id.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- event_i  in  NUM_EVENTS  per-event increment pulse; bit i adds 1 to counter i this cycle.
- dump_req  in  1  start snapshot and stream; sampled only in IDLE.
- clear_on_dump  in  1  sampled with dump_req; 1 means live counters are cleared at snapshot.
- clear_req  in  1  clear all live counters; never affects an in-flight snapshot.
- busy  out  1  high from the cycle after an accepted dump_req until the final handshake completes.
- out_valid  out  1  stream entry valid.
- out_ready  in  1  consumer accept.
- out_id  out  ID_WIDTH  counter index of the entry.
- out_count  out  CNT_WIDTH  snapshotted counter value.
- out_last  out  1  entry is the final entry of this dump.

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset: all live counters, shadow registers and index = 0; state IDLE; busy, out_valid and out_last = 0; out_id and out_count = 0.
- Live counters:
  - Counter i increments by 1 on event_i[i].
  - It saturates at all-ones; no wrap.
- clear_req:
  - Live counter becomes 0, or 1 if event_i[i] is high that same cycle.
  - Has the same effect in every state.
- FSM states: IDLE, SEND.
- IDLE, dump_req=1 at edge T:
  - Shadow[i] <= live value before this cycle's increment.
  - If clear_on_dump=1 (or clear_req=1), live counter becomes event_i[i] (0 or 1); otherwise it keeps counting normally.
  - index <= 0; state <= SEND at T+1; busy=1 and out_valid=1 from T+1 with out_id=0.
  - Latency from dump_req to first valid entry: 1 cycle.
- SEND:
  - out_id=index, out_count=shadow[index], out_last=(index==NUM_EVENTS-1).
  - On out_valid && out_ready: index+1, or return to IDLE if last. busy and out_valid drop the cycle after the last handshake.
  - If out_ready=0: out_id, out_count and out_last stay stable and out_valid stays high (AXI-stream rules; valid never retracts).
- dump_req while busy: ignored; no queuing and no effect on the snapshot.
- dump_req in the cycle busy falls (IDLE again): accepted normally.
- Events during SEND: counted into live counters only; the snapshot is unaffected.
- Reset mid-stream: stream aborts immediately and all outputs return to reset values next cycle; the consumer must discard the partial dump.
- Back-to-back: with out_ready held high, a full dump takes exactly NUM_EVENTS cycles of out_valid.

Optional Feature:
- Macro: PERF_DUMP_SKIP_ZERO_EN.
- Defined:
  - In SEND, entries whose shadow value is 0 are skipped. Each skipped index spends one cycle with out_valid=0 while index advances.
  - Index NUM_EVENTS-1 is always emitted, even if 0, as the terminator with out_last=1.
- Undefined: every index 0..NUM_EVENTS-1 is emitted in order.

Test Plan:
- Reset, then 5 pulses on event 3 and 2 on event 0, dump_req with out_ready=1 -> 16 consecutive entries starting one cycle after dump_req; id0=2, id3=5, others 0; out_last only on id 15; busy low afterwards.
- Counter forced to 0xFFFFFFFE, then 3 pulses, dump -> out_count=0xFFFFFFFF (saturated, no wrap).
- dump_req with clear_on_dump=1 and event_i[1]=1 in the same cycle, prior count 7 -> entry id1=7; a second dump reports id1=1 plus any later events.
- out_ready toggled 1,0,0,1 during SEND -> out_id and out_count held stable while stalled; a dump_req pulsed mid-stream is ignored (exactly one stream of 16 entries).
- rst asserted at index 6 -> out_valid=0 and busy=0 next cycle, all counters read 0 on the next dump.
- With PERF_DUMP_SKIP_ZERO_EN: only counters 2 and 9 nonzero -> exactly three valid entries (ids 2, 9, 15), out_last on id 15 with count 0.
